// File: rtl/csa_resolver.sv
// Resolves one carry-save (sum, carry) row pair to binary using a
// multi-cycle chunked carry-propagate adder, CHUNK_W bits per cycle.
module csa_resolver #(
    parameter int DATA_W  = 15,
    parameter int CHUNK_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_sum,
    input  logic [DATA_W-1:0] i_carry,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W:0]   o_data,
    output logic              o_busy
);

    localparam int NCHUNK = (DATA_W + CHUNK_W - 1) / CHUNK_W;
    localparam int PW     = NCHUNK * CHUNK_W;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          carry;
    logic [PW-1:0] a_q;
    logic [PW-1:0] b_q;
    logic [PW:0]   res_q;
    logic [CHUNK_W:0] chunk_sum;
    logic          last;

    assign chunk_sum = {1'b0, a_q[cnt*CHUNK_W +: CHUNK_W]}
                     + {1'b0, b_q[cnt*CHUNK_W +: CHUNK_W]}
                     + {{CHUNK_W{1'b0}}, carry};
    assign last = (cnt == CW'(NCHUNK - 1));

    // Top bit is the padded chunk's result bit, or the final carry when
    // the rows fill the padded width exactly.
    assign o_data = res_q[DATA_W:0];

    generate
        if (PW > DATA_W) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^res_q[PW:DATA_W+1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            carry   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            o_ready <= 1'b0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    o_ready <= 1'b1;
                    if (o_ready && i_valid) begin
                        a_q     <= PW'(i_sum);
                        b_q     <= PW'(i_carry);
                        cnt     <= '0;
                        carry   <= 1'b0;
                        o_ready <= 1'b0;
                        o_busy  <= 1'b1;
                        state   <= S_ADD;
                    end
                end
                S_ADD: begin
                    res_q[cnt*CHUNK_W +: CHUNK_W] <= chunk_sum[CHUNK_W-1:0];
                    carry <= chunk_sum[CHUNK_W];
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        res_q[PW] <= chunk_sum[CHUNK_W];
                        o_valid   <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_busy  <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_resolver.sv
// Directed and random checks of csa_resolver at CHUNK_W = 4, 15 and 1.
module tb_csa_resolver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        vi  [3];
    logic        rdy [3];
    logic        vld [3];
    logic        ri  [3];
    logic        bsy [3];
    logic [14:0] sa  [3];
    logic [14:0] ca  [3];
    logic [15:0] od  [3];

    csa_resolver #(.DATA_W(15), .CHUNK_W(4)) u0 (
        .clk(clk), .rst(rst), .i_valid(vi[0]), .o_ready(rdy[0]),
        .i_sum(sa[0]), .i_carry(ca[0]), .o_valid(vld[0]),
        .i_ready(ri[0]), .o_data(od[0]), .o_busy(bsy[0])
    );
    csa_resolver #(.DATA_W(15), .CHUNK_W(15)) u1 (
        .clk(clk), .rst(rst), .i_valid(vi[1]), .o_ready(rdy[1]),
        .i_sum(sa[1]), .i_carry(ca[1]), .o_valid(vld[1]),
        .i_ready(ri[1]), .o_data(od[1]), .o_busy(bsy[1])
    );
    csa_resolver #(.DATA_W(15), .CHUNK_W(1)) u2 (
        .clk(clk), .rst(rst), .i_valid(vi[2]), .o_ready(rdy[2]),
        .i_sum(sa[2]), .i_carry(ca[2]), .o_valid(vld[2]),
        .i_ready(ri[2]), .o_data(od[2]), .o_busy(bsy[2])
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [14:0] a;
        logic [14:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic run_op(input int d, input logic [14:0] a,
                          input logic [14:0] b, input logic [15:0] exp,
                          input int exp_lat, input string name);
        int w;
        int lat;
        w = 0;
        @(negedge clk);
        while (!rdy[d] && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({name, "_ready"}, 32'(rdy[d]), 1);
        if (!rdy[d]) return;
        vi[d] = 1'b1;
        sa[d] = a;
        ca[d] = b;
        @(posedge clk);
        #1;
        vi[d] = 1'b0;
        sa[d] = 'x;
        ca[d] = 'x;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (vld[d]) begin
                lat = k;
                break;
            end
        end
        check({name, "_lat"}, lat, exp_lat);
        if (lat > 0) check({name, "_data"}, od[d], exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int t1, t2, nv;
        logic acc;
        logic [15:0] got [$];
        logic [14:0] ra, rb;

        vecs[0] = '{15'h7FFF, 15'h0001, 16'h8000};
        vecs[1] = '{15'h7FFF, 15'h7FFF, 16'hFFFE};
        vecs[2] = '{15'h0000, 15'h0000, 16'h0000};
        vecs[3] = '{15'h1234, 15'h0FFF, 16'h2233};
        vecs[4] = '{15'h4000, 15'h4000, 16'h8000};
        vecs[5] = '{15'h5555, 15'h2AAA, 16'h7FFF};
        vecs[6] = '{15'h7FFF, 15'h0000, 16'h7FFF};

        for (int d = 0; d < 3; d++) begin
            vi[d] = 1'b0;
            ri[d] = 1'b1;
            sa[d] = '0;
            ca[d] = '0;
        end

        // reset state, ready held low while rst is high
        @(negedge clk);
        check("rst_ready", 32'(rdy[0]), 0);
        check("rst_valid", 32'(vld[0]), 0);
        check("rst_busy", 32'(bsy[0]), 0);
        check("rst_data", od[0], 0);
        @(negedge clk);
        check("rst_ready_hold", 32'(rdy[0]), 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_rst", 32'(rdy[0]), 1);

        for (int i = 0; i < 7; i++)
            run_op(0, vecs[i].a, vecs[i].b, vecs[i].exp, 4,
                   $sformatf("vec%0d", i));

        // backpressure in DONE
        @(negedge clk);
        ri[0] = 1'b0;
        vi[0] = 1'b1;
        sa[0] = 15'h0100;
        ca[0] = 15'h0200;
        @(posedge clk);
        #1;
        vi[0] = 1'b0;
        t1 = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (vld[0]) begin
                t1 = k;
                break;
            end
        end
        check("bp_lat", t1, 4);
        for (int i = 0; i < 5; i++) begin
            vi[0] = (i % 2 == 0);
            sa[0] = 15'($urandom);
            ca[0] = 15'($urandom);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp_data%0d", i), od[0], 16'h0300);
            check($sformatf("bp_ready%0d", i), 32'(rdy[0]), 0);
            check($sformatf("bp_valid%0d", i), 32'(vld[0]), 1);
        end
        vi[0] = 1'b0;
        ri[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_valid", 32'(vld[0]), 0);
        check("bp_release_ready", 32'(rdy[0]), 1);
        check("bp_release_busy", 32'(bsy[0]), 0);
        check("bp_idle_hold", od[0], 16'h0300);

        // back-to-back with i_valid tied high
        t1 = -1;
        t2 = -1;
        vi[0] = 1'b1;
        sa[0] = 15'h1234;
        ca[0] = 15'h0FFF;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (vld[0]) got.push_back(od[0]);
            acc = rdy[0] && vi[0];
            if (acc) begin
                if (t1 < 0) t1 = cyc;
                else if (t2 < 0) t2 = cyc;
            end
            @(posedge clk);
            #1;
            if (acc && t1 == cyc) begin
                sa[0] = 15'h4000;
                ca[0] = 15'h4000;
            end else if (acc) begin
                vi[0] = 1'b0;
            end
            @(negedge clk);
        end
        vi[0] = 1'b0;
        check("b2b_spacing", t2 - t1, 6);
        check("b2b_count", got.size(), 2);
        if (got.size() >= 2) begin
            check("b2b_data0", got[0], 16'h2233);
            check("b2b_data1", got[1], 16'h8000);
        end

        // async reset after two ADD cycles
        @(negedge clk);
        vi[0] = 1'b1;
        sa[0] = 15'h7FFF;
        ca[0] = 15'h0001;
        @(posedge clk);
        #1;
        vi[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_busy", 32'(bsy[0]), 1);
        check("mid_data_pre", od[0], 16'h8000);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(vld[0]), 0);
        check("mid_rst_data", od[0], 0);
        check("mid_rst_busy", 32'(bsy[0]), 0);
        check("mid_rst_ready", 32'(rdy[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (vld[0]) nv++;
        end
        check("mid_no_output", nv, 0);
        run_op(0, 15'h0ABC, 15'h0123, 16'h0BDF, 4, "post_rst");

        // config sweep: NCHUNK = 1 and NCHUNK = 15
        for (int d = 1; d < 3; d++) begin
            for (int i = 0; i < 1000; i++) begin
                ra = 15'($urandom);
                rb = 15'($urandom);
                run_op(d, ra, rb, {1'b0, ra} + {1'b0, rb},
                       (d == 1) ? 1 : 15, $sformatf("sweep%0d_%0d", d, i));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
